// File: rtl/lockin_pkg.sv
// Shared types and default widths for the lock-in integration stage.
package lockin_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int DEF_IN_W  = 64;
  localparam int DEF_ACC_W = 96;
  localparam int DEF_CNT_W = 32;

endpackage

// File: rtl/acc_channel.sv
// One signed accumulate channel: sign-extends each sample, sums it, and dumps
// the finished window total (including the final sample) into a held output.
module acc_channel
  import lockin_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    add_en,
  input  logic                    dump,
  input  logic signed [IN_W-1:0]  din,
  output logic signed [ACC_W-1:0] sum_out
);

  logic signed [ACC_W-1:0] din_ext;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] out_q, out_d;

  assign din_ext = {{(ACC_W-IN_W){din[IN_W-1]}}, din};

  always_comb begin
    acc_d = acc_q;
    out_d = out_q;
    if (clr) begin
      acc_d = '0;
    end else if (dump) begin
      // The final sample goes straight into the output, never into acc.
      out_d = acc_q + din_ext;
      acc_d = '0;
    end else if (add_en) begin
      acc_d = acc_q + din_ext;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q <= '0;
      out_q <= '0;
    end else begin
      acc_q <= acc_d;
      out_q <= out_d;
    end
  end

  assign sum_out = out_q;

endmodule

// File: rtl/cycle_accumulator.sv
// Integrates in-phase and quadrature products over ptos_x_ciclo*ciclos valid
// samples and emits one pair of window sums per window.
module cycle_accumulator
  import lockin_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [15:0]             ptos_x_ciclo,
  input  logic [15:0]             ciclos,
  input  logic signed [IN_W-1:0]  data_in_fase,
  input  logic signed [IN_W-1:0]  data_in_cuadratura,
  input  logic                    data_valid,
  output logic signed [ACC_W-1:0] data_out_fase,
  output logic signed [ACC_W-1:0] data_out_cuadratura,
  output logic                    data_valid_out,
  output logic                    busy
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] n_lat_q, n_lat_d;
  logic             pulse_q, pulse_d;
  logic [31:0]      n_prod;
  logic [CNT_W-1:0] n_cfg;
  logic             clr, add_en, dump;

  assign n_prod = {16'd0, ptos_x_ciclo} * {16'd0, ciclos};
  assign n_cfg  = CNT_W'(n_prod);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_lat_d = n_lat_q;
    pulse_d = 1'b0;
    clr     = 1'b0;
    add_en  = 1'b0;
    dump    = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && (n_cfg != '0)) begin
          state_d = RUN;
          n_lat_d = n_cfg;
          cnt_d   = '0;
          clr     = 1'b1;
        end
      end
      RUN: begin
        if (!enable) begin
          // Abandon the partial window silently.
          state_d = IDLE;
          cnt_d   = '0;
          clr     = 1'b1;
        end else if (data_valid) begin
          if (cnt_q == n_lat_q - CNT_W'(1)) begin
            dump    = 1'b1;
            pulse_d = 1'b1;
            cnt_d   = '0;
            n_lat_d = n_cfg;
            if (n_cfg == '0) state_d = IDLE;
          end else begin
            add_en = 1'b1;
            cnt_d  = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_lat_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_lat_q <= n_lat_d;
      pulse_q <= pulse_d;
    end
  end

  acc_channel #(.IN_W(IN_W), .ACC_W(ACC_W)) u_fase (
    .clock   (clock),
    .reset   (reset),
    .clr     (clr),
    .add_en  (add_en),
    .dump    (dump),
    .din     (data_in_fase),
    .sum_out (data_out_fase)
  );

  acc_channel #(.IN_W(IN_W), .ACC_W(ACC_W)) u_cuad (
    .clock   (clock),
    .reset   (reset),
    .clr     (clr),
    .add_en  (add_en),
    .dump    (dump),
    .din     (data_in_cuadratura),
    .sum_out (data_out_cuadratura)
  );

  assign data_valid_out = pulse_q;
  assign busy           = (state_q == RUN);

endmodule

// File: tb/tb_cycle_accumulator.sv
// Self-checking bench for cycle_accumulator: directed scenarios plus random
// traffic, every cycle compared against a window-level reference model.
module tb_cycle_accumulator;

  logic               clock = 1'b0;
  logic               reset;
  logic               enable;
  logic [15:0]        ptos_x_ciclo;
  logic [15:0]        ciclos;
  logic signed [63:0] data_in_fase;
  logic signed [63:0] data_in_cuadratura;
  logic               data_valid;
  logic signed [95:0] data_out_fase;
  logic signed [95:0] data_out_cuadratura;
  logic               data_valid_out;
  logic               busy;

  int vec_cnt = 0;
  int err_cnt = 0;
  int pulse_cnt = 0;

  // Reference model state: window progress, running sums, held outputs.
  bit                 m_run;
  int unsigned        m_n;
  int unsigned        m_seen;
  logic signed [95:0] m_sf, m_sc, m_of, m_oc;
  bit                 m_pulse;

  always #5 clock = ~clock;

  cycle_accumulator dut (
    .clock               (clock),
    .reset               (reset),
    .enable              (enable),
    .ptos_x_ciclo        (ptos_x_ciclo),
    .ciclos              (ciclos),
    .data_in_fase        (data_in_fase),
    .data_in_cuadratura  (data_in_cuadratura),
    .data_valid          (data_valid),
    .data_out_fase       (data_out_fase),
    .data_out_cuadratura (data_out_cuadratura),
    .data_valid_out      (data_valid_out),
    .busy                (busy)
  );

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    int unsigned n_now;
    logic signed [95:0] ef, ec;
    n_now   = int'(ptos_x_ciclo) * int'(ciclos);
    ef      = 96'(data_in_fase);
    ec      = 96'(data_in_cuadratura);
    m_pulse = 1'b0;
    if (reset) begin
      m_run = 0; m_n = 0; m_seen = 0;
      m_sf = 0; m_sc = 0; m_of = 0; m_oc = 0;
    end else if (!m_run) begin
      if (enable && n_now != 0) begin
        m_run = 1; m_n = n_now; m_seen = 0; m_sf = 0; m_sc = 0;
      end
    end else if (!enable) begin
      m_run = 0; m_seen = 0; m_sf = 0; m_sc = 0;
    end else if (data_valid) begin
      m_sf += ef;
      m_sc += ec;
      m_seen++;
      if (m_seen == m_n) begin
        m_of = m_sf; m_oc = m_sc; m_pulse = 1'b1;
        m_sf = 0; m_sc = 0; m_seen = 0;
        m_n = n_now;
        if (n_now == 0) m_run = 0;
      end
    end
  endtask

  task automatic tick(input bit full = 1'b1);
    @(posedge clock);
    model_edge();
    #1;
    if (data_valid_out) pulse_cnt++;
    chk("valid_out", 96'(data_valid_out), 96'(m_pulse));
    chk("busy", 96'(busy), 96'(m_run));
    if (full || m_pulse) begin
      chk("out_fase", data_out_fase, m_of);
      chk("out_cuad", data_out_cuadratura, m_oc);
    end
  endtask

  task automatic set_cfg(input int p, input int c, input longint f, input longint q);
    ptos_x_ciclo       = 16'(p);
    ciclos             = 16'(c);
    data_in_fase       = f;
    data_in_cuadratura = q;
  endtask

  initial begin
    logic signed [95:0] big_f, big_c;
    reset = 1'b1; enable = 1'b0; data_valid = 1'b0;
    set_cfg(4, 2, 10, -3);
    tick(); tick();
    reset = 1'b0;

    // Continuous stream, 8-sample windows.
    enable = 1'b1; data_valid = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    chk("cont_fase_80", data_out_fase, 96'sd80);
    chk("cont_cuad_-24", data_out_cuadratura, -96'sd24);

    // Sparse valid pattern 1,0,0.
    for (int i = 0; i < 60; i++) begin
      data_valid = (i % 3 == 0);
      tick();
    end

    // Drop enable mid-window, then resume.
    data_valid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    pulse_cnt = 0;
    enable = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("reenable_pulses", 96'(pulse_cnt), 96'd1);
    chk("reenable_fase_80", data_out_fase, 96'sd80);

    // Zero window length keeps the block idle.
    reset = 1'b1; tick(); reset = 1'b0;
    set_cfg(0, 2, 10, -3);
    pulse_cnt = 0;
    for (int i = 0; i < 100; i++) tick();
    chk("n0_pulses", 96'(pulse_cnt), 96'd0);

    // Change ciclos mid-window: 8 then 12.
    set_cfg(4, 2, 7, 5);
    for (int i = 0; i < 4; i++) tick();
    ciclos = 16'd3;
    for (int i = 0; i < 40; i++) tick();

    // Reset mid-window.
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst_fase_zero", data_out_fase, 96'sd0);
    enable = 1'b0; tick(); enable = 1'b1;

    // Random traffic with occasional config and enable changes.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 40) == 0) begin
        ptos_x_ciclo = 16'($urandom_range(0, 4));
        ciclos       = 16'($urandom_range(0, 3));
      end
      enable             = ($urandom_range(0, 60) != 0);
      data_valid         = $urandom_range(0, 3) != 0;
      data_in_fase       = {$urandom, $urandom};
      data_in_cuadratura = {$urandom, $urandom};
      reset              = ($urandom_range(0, 500) == 0);
      tick();
    end
    reset = 1'b0;

    // Extremes: full 16-bit window with most-negative / most-positive inputs.
    enable = 1'b0; tick();
    set_cfg(65535, 1, 64'sh8000_0000_0000_0000, 64'sh7FFF_FFFF_FFFF_FFFF);
    data_valid = 1'b1; enable = 1'b1;
    pulse_cnt = 0;
    for (int i = 0; i < 65540; i++) tick(1'b0);
    big_f = -(96'sd65535 <<< 63);
    big_c = 96'sd65535 * 96'sh7FFF_FFFF_FFFF_FFFF;
    chk("ext_pulses", 96'(pulse_cnt), 96'd1);
    chk("ext_fase", data_out_fase, big_f);
    chk("ext_cuad", data_out_cuadratura, big_c);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/cycle_accumulator.md
Name: cycle_accumulator

Overview:
Lock-in stage directly downstream of the reference multiplier. It integrates the 64-bit in-phase (data×sin) and quadrature (data×cos) products over an integer number of reference periods. Each window holds ptos_x_ciclo × ciclos valid samples. At the end of each window it emits one pair of sums, which acts as the low-pass/DC-extraction step feeding magnitude/phase computation and readout.

Parameters:
IN_W, 64, width of each signed product input
ACC_W, 96, width of each signed accumulator and output; must be >= IN_W+32 so a full window can never overflow
CNT_W, 32, width of the window sample counter; holds up to 65535×65535

Ports:
clock  in  1  system clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  run control; low holds the block idle
ptos_x_ciclo  in  16  samples per reference period
ciclos  in  16  periods per integration window
data_in_fase  in  IN_W  signed in-phase product
data_in_cuadratura  in  IN_W  signed quadrature product
data_valid  in  1  qualifies both inputs this cycle
data_out_fase  out  ACC_W  signed in-phase window sum
data_out_cuadratura  out  ACC_W  signed quadrature window sum
data_valid_out  out  1  one-cycle pulse; outputs are new
busy  out  1  high while a window is in progress

Behaviour:
- Reset (reset=1 at a clock edge): state=IDLE; both accumulators, counter, data_out_* and data_valid_out are 0; busy=0. Reset wins over every other input in the same cycle.
- Window length: N = ptos_x_ciclo × ciclos, an unsigned 32-bit product. It is latched into n_lat on entering RUN. Config changes during a window have no effect until the next window starts.
- States:
  - IDLE → RUN when enable=1 and N≠0. The accumulators and counter are 0 on entry.
  - RUN → IDLE when enable=0. The partial window is discarded: accumulators and counter are cleared, and no output pulse is produced.
  - RUN stays in RUN at a window boundary. The next window starts with a freshly latched N. If that new N=0, go to IDLE.
- A sample is accepted in RUN when data_valid=1. Each accepted sample:
  - sign-extends both inputs to ACC_W and adds them to their accumulators;
  - increments the counter.
- Samples with data_valid=0 are ignored. Gaps of any length are allowed.
- Final sample of a window (counter = n_lat−1 and data_valid=1), all at the same edge:
  - data_out_* <= acc + sign-extended input;
  - accumulators and counter are cleared;
  - data_valid_out=1 on the next cycle only.
- Latency is 1 cycle from the last valid sample to the data_valid_out pulse.
- A data_valid arriving on the cycle after the final sample counts as sample 0 of the next window. No samples are dropped on a continuous stream.
- data_out_* hold their value between pulses.
- busy = (state==RUN).
- enable=1 in IDLE with N=0: the block stays idle and never outputs.
- Arithmetic is two's complement, with no saturation and no rounding. Full precision is guaranteed by the ACC_W rule.

Decomposition:
- Shared package lockin_pkg holds:
  - state enum (IDLE, RUN);
  - default widths IN_W=64, ACC_W=96, CNT_W=32.
- Sub-module acc_channel: one signed sign-extend-and-accumulate register with clear, add-enable and dump. It is instantiated twice (fase and cuadratura).
- The counter and FSM live in the top module.

Test Plan:
- Continuous stream, ptos_x_ciclo=4, ciclos=2, fase=10, cuadratura=−3 on every cycle → data_valid_out pulses on the cycle after the 8th sample with outputs 80 / −24. The next pulse comes exactly 8 cycles later with the same values.
- Same config, data_valid toggling 1,0,0,1,… → same sums; each pulse comes 1 cycle after the 8th valid sample; invalid cycles do not change the sums.
- Drop enable after 5 samples, then raise it again → no pulse for the partial window. The next pulse fires 8 valid samples after re-enable with sum 80.
- ptos_x_ciclo=0 with enable=1 for 100 cycles → busy=0 and data_valid_out never asserts.
- Extremes with ptos_x_ciclo=65535, ciclos=1, fase=−2^63, cuadratura=2^63−1 → outputs −65535×2^63 and 65535×(2^63−1), exact, with no wrap.
- Change ciclos from 2 to 3 mid-window; separately, pulse reset mid-window:
  - config change → the current window still closes after 8 samples, the following window after 12;
  - reset → all outputs are 0 next cycle and no pulse is emitted.
